// File: rtl/buscli_vio_seq.sv
// Debug-host bus client: turns toggle-handshaked host commands into single
// bus transactions and reports the result on a registered status word.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for the command toggle to differ from the accepted one
// SETTLE | command captured; needs 2 consecutive stable cycles to dispatch
// ISSUE  | bus_req held until ack / err / timeout
// DONE   | publish address and toggle echo, then back to IDLE
module buscli_vio_seq #(
    parameter int adda_width     = 68,
    parameter int stat_width     = 68,
    parameter int timeout_cycles = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [adda_width-1:0] adda_in,
    output logic [stat_width-1:0] stat_out,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ack,
    input  logic                  bus_err,
    input  logic [31:0]           bus_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] OP_WRITE = 3'b001;
    localparam logic [2:0] OP_READ  = 3'b010;
    localparam logic [2:0] OP_CLEAR = 3'b100;

    // Last ISSUE cycle index; the compare happens in the final allowed cycle
    // so bus_req stays high for exactly timeout_cycles cycles.
    localparam logic [15:0] TO_LAST = 16'(timeout_cycles - 1);

    logic [1:0]            state_q, state_d;
    logic [adda_width-1:0] cap_q, cap_d;
    logic                  stable_q, stable_d;
    logic                  acc_q, acc_d;
    logic [15:0]           wait_q, wait_d;

    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  st_tog_q, st_tog_d;
    logic                  st_busy_q, st_busy_d;
    logic                  st_err_q, st_err_d;
    logic                  st_to_q, st_to_d;
    logic [31:0]           st_addr_q, st_addr_d;
    logic [31:0]           st_data_q, st_data_d;

    // Next-state and datapath decode for the sequencer.
    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        stable_d  = stable_q;
        acc_d     = acc_q;
        wait_d    = wait_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        st_tog_d  = st_tog_q;
        st_err_d  = st_err_q;
        st_to_d   = st_to_q;
        st_addr_d = st_addr_q;
        st_data_d = st_data_q;

        case (state_q)
            S_IDLE: begin
                if (adda_in[67] != acc_q) begin
                    cap_d    = adda_in;
                    stable_d = 1'b0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (adda_in[67] == acc_q) begin
                    // host withdrew the command before it settled
                    state_d = S_IDLE;
                end else if (adda_in != cap_q) begin
                    cap_d    = adda_in;
                    stable_d = 1'b0;
                end else if (!stable_q) begin
                    stable_d = 1'b1;
                end else begin
                    acc_d = cap_q[67];
                    case (cap_q[66:64])
                        OP_WRITE, OP_READ: begin
                            req_d   = 1'b1;
                            we_d    = (cap_q[66:64] == OP_WRITE);
                            addr_d  = cap_q[63:32];
                            wdata_d = cap_q[31:0];
                            wait_d  = 16'd0;
                            state_d = S_ISSUE;
                        end
                        OP_CLEAR: begin
                            st_err_d = 1'b0;
                            st_to_d  = 1'b0;
                            state_d  = S_DONE;
                        end
                        default: begin
                            st_err_d = 1'b1;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                wait_d = wait_q + 16'd1;
                if (bus_err) begin
                    req_d     = 1'b0;
                    st_err_d  = 1'b1;
                    st_to_d   = 1'b0;
                    st_data_d = 32'h0;
                    state_d   = S_DONE;
                end else if (bus_ack) begin
                    req_d     = 1'b0;
                    st_err_d  = 1'b0;
                    st_to_d   = 1'b0;
                    st_data_d = we_q ? wdata_q : bus_rdata;
                    state_d   = S_DONE;
                end else if (wait_q == TO_LAST) begin
                    req_d     = 1'b0;
                    st_err_d  = 1'b0;
                    st_to_d   = 1'b1;
                    st_data_d = 32'hDEAD_DEAD;
                    state_d   = S_DONE;
                end
            end
            default: begin
                // echo last so the host sees it only once everything is final
                st_addr_d = cap_q[63:32];
                st_tog_d  = acc_q;
                state_d   = S_IDLE;
            end
        endcase

        st_busy_d = (state_d != S_IDLE);
    end

    // State, bus and status registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cap_q     <= '0;
            stable_q  <= 1'b0;
            acc_q     <= 1'b0;
            wait_q    <= 16'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            st_tog_q  <= 1'b0;
            st_busy_q <= 1'b0;
            st_err_q  <= 1'b0;
            st_to_q   <= 1'b0;
            st_addr_q <= 32'h0;
            st_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            stable_q  <= stable_d;
            acc_q     <= acc_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            st_tog_q  <= st_tog_d;
            st_busy_q <= st_busy_d;
            st_err_q  <= st_err_d;
            st_to_q   <= st_to_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
        end
    end

    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign stat_out  = {st_tog_q, st_busy_q, st_err_q, st_to_q, st_addr_q, st_data_q};

endmodule
